// File: rtl/dpram_drain_pkg.sv
// Shared types and constants for the DPRAM-to-byte-stream drain.
// Optional feature macro: DRAIN_CKSUM_EN adds the trailing checksum state.
package dpram_drain_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CKSUM_WIDTH    = 16;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LAT   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
`ifdef DRAIN_CKSUM_EN
    ,
    ST_CKSUM = 3'd5
`endif
  } drain_state_e;

  function automatic logic [CKSUM_WIDTH-1:0] cksum_add(
    input logic [CKSUM_WIDTH-1:0] acc,
    input logic [7:0]             data_byte
  );
    return acc + CKSUM_WIDTH'(data_byte);
  endfunction

endpackage

// File: rtl/drain_word_ser.sv
// Holds one 32-bit word and emits it MSB byte first over a valid/ready port.
// The last byte index is loadable so shorter trailers reuse the same path.
module drain_word_ser
  import dpram_drain_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [31:0]           load_data_i,
  input  logic [BYTE_IDX_W-1:0] load_last_idx_i,
  input  logic                  m_ready_i,
  output logic [7:0]            m_data_o,
  output logic                  m_valid_o,
  output logic                  last_byte_o,
  output logic                  word_done_o
);

  logic [31:0]           shreg_q, shreg_d;
  logic                  valid_q, valid_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [BYTE_IDX_W-1:0] last_idx_q, last_idx_d;
  logic                  fire;

  assign fire        = valid_q & m_ready_i;
  assign last_byte_o = valid_q & (idx_q == last_idx_q);
  assign word_done_o = fire & (idx_q == last_idx_q);
  assign m_data_o    = shreg_q[31:24];
  assign m_valid_o   = valid_q;

  always_comb begin
    // NOTE: every _d starts from its _q, so no branch can leave a latch behind.
    shreg_d    = shreg_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    if (load_i) begin
      shreg_d    = load_data_i;
      valid_d    = 1'b1;
      idx_d      = '0;
      last_idx_d = load_last_idx_i;
    end else if (fire) begin
      // Zero-fill keeps m_data at 0 once a word has fully drained.
      shreg_d = {shreg_q[23:0], 8'h00};
      idx_d   = idx_q + 1'b1;
      if (idx_q == last_idx_q) begin
        valid_d = 1'b0;
      end
    end
  end

  // NOTE: rst is only looked at on the clock edge (synchronous), so it stays
  // out of the sensitivity list; non-blocking keeps all registers edge-aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q    <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: rtl/dpram_stream_drain.sv
// Drains dpram_len 32-bit DPRAM words as an MSB-first byte stream with m_last.
// Optional feature macro: DRAIN_CKSUM_EN appends a 16-bit byte-sum trailer.
module dpram_stream_drain
  import dpram_drain_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dpram_run,
  input  logic [P_LEN_WIDTH-1:0]  dpram_len,
  output logic                    dpram_busy,
  output logic                    dpram_done,
  output logic [P_ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]             rd_data,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last
);

  localparam int CNT_W = P_ADDR_WIDTH + 1;
  localparam int CMP_W = (P_LEN_WIDTH > CNT_W) ? P_LEN_WIDTH : CNT_W;
  localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << P_ADDR_WIDTH;

  drain_state_e            state_q, state_d;
  logic [CNT_W-1:0]        words_q, words_d;
  logic [P_ADDR_WIDTH-1:0] idx_q, idx_d;

  logic [CMP_W-1:0]        len_ext;
  logic [CNT_W-1:0]        len_clamped;
  logic                    last_word;

  logic                    ser_load;
  logic [31:0]             ser_load_data;
  logic [BYTE_IDX_W-1:0]   ser_last_idx;
  logic                    ser_last_byte;
  logic                    ser_word_done;

`ifdef DRAIN_CKSUM_EN
  logic [CKSUM_WIDTH-1:0]  cksum_q, cksum_d;
  logic [CKSUM_WIDTH-1:0]  cksum_next;
  logic                    ser_fire;

  assign ser_fire   = m_valid & m_ready;
  assign cksum_next = cksum_add(cksum_q, m_data);
`endif

  // Addresses never wrap: anything above the DPRAM depth is trimmed to it.
  assign len_ext     = CMP_W'(dpram_len);
  assign len_clamped = (len_ext > MAX_WORDS) ? CNT_W'(MAX_WORDS) : CNT_W'(len_ext);
  assign last_word   = (CNT_W'(idx_q) == (words_q - CNT_W'(1)));

  always_comb begin
    state_d       = state_q;
    words_d       = words_q;
    idx_d         = idx_q;
    ser_load      = 1'b0;
    ser_load_data = rd_data;
    ser_last_idx  = BYTE_IDX_W'(BYTES_PER_WORD - 1);
`ifdef DRAIN_CKSUM_EN
    cksum_d       = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dpram_run) begin
          words_d = len_clamped;
          idx_d   = '0;
`ifdef DRAIN_CKSUM_EN
          cksum_d = '0;
`endif
          state_d = (dpram_len == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD:  state_d = ST_LAT;
      ST_LAT: begin
        // rd_data now holds the word addressed during RD.
        ser_load = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
`ifdef DRAIN_CKSUM_EN
        if (ser_fire) begin
          cksum_d = cksum_next;
        end
`endif
        if (ser_word_done) begin
          if (!last_word) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RD;
          end else begin
`ifdef DRAIN_CKSUM_EN
            // The trailer reuses the serializer; cksum_next already holds the final byte.
            ser_load      = 1'b1;
            ser_load_data = {cksum_next, {(32 - CKSUM_WIDTH){1'b0}}};
            ser_last_idx  = BYTE_IDX_W'(CKSUM_WIDTH / 8 - 1);
            state_d       = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef DRAIN_CKSUM_EN
      ST_CKSUM: begin
        if (ser_word_done) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      idx_q   <= '0;
`ifdef DRAIN_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      idx_q   <= idx_d;
`ifdef DRAIN_CKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  drain_word_ser u_ser (
    .clk             (clk),
    .rst             (rst),
    .load_i          (ser_load),
    .load_data_i     (ser_load_data),
    .load_last_idx_i (ser_last_idx),
    .m_ready_i       (m_ready),
    .m_data_o        (m_data),
    .m_valid_o       (m_valid),
    .last_byte_o     (ser_last_byte),
    .word_done_o     (ser_word_done)
  );

  assign dpram_busy = (state_q != ST_IDLE);
  assign dpram_done = (state_q == ST_DONE);
  assign rd_addr    = idx_q;
`ifdef DRAIN_CKSUM_EN
  assign m_last     = ser_last_byte & (state_q == ST_CKSUM);
`else
  assign m_last     = ser_last_byte & (state_q == ST_SHIFT) & last_word;
`endif

endmodule

// File: tb/tb_dpram_stream_drain.sv
// Directed bench for dpram_stream_drain: a DPRAM model, a byte scoreboard
// filled when each frame starts, and cycle-accurate latency and done checks.
module tb_dpram_stream_drain;

  localparam int AW     = 10;
  localparam int LW     = 16;
  localparam int DEPTH  = 1 << AW;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          dpram_run;
  logic [LW-1:0] dpram_len;
  logic          dpram_busy;
  logic          dpram_done;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [DEPTH];
  int          vectors     = 0;
  int          miscompares = 0;
  int          done_pulses = 0;
  logic        prev_stall  = 1'b0;
  logic [7:0]  prev_data   = 8'h00;

  always #5 clk = ~clk;

  dpram_stream_drain #(.P_ADDR_WIDTH(AW), .P_LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .dpram_run  (dpram_run),
    .dpram_len  (dpram_len),
    .dpram_busy (dpram_busy),
    .dpram_done (dpram_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  // Synchronous-read DPRAM: data appears the cycle after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, m_last only with a byte.
  always @(negedge clk) begin
    if (rst && prev_stall) begin
      check("stall_valid_held", m_valid, 1);
      check("stall_data_held", m_data, prev_data);
    end
    if (rst && m_valid && m_ready) begin
      check("byte_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("byte_data", m_data, e.data);
        check("byte_last", m_last, e.last);
      end
    end
    if (!m_valid) check("last_needs_valid", m_last, 0);
    if (dpram_done) done_pulses++;
    prev_stall <= rst && m_valid && !m_ready;
    prev_data  <= m_data;
  end

  function automatic int words_of(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  function automatic int expected_done(input int len);
    int n;
    n = words_of(len);
    if (n == 0) return 1;
`ifdef DRAIN_CKSUM_EN
    return 6 * n + 3;
`else
    return 6 * n + 1;
`endif
  endfunction

  task automatic load_expect(input int len);
    int          n;
    logic [15:0] sum;
    logic [31:0] w;
    exp_t        e;
    n   = words_of(len);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      w = mem[i];
      for (int b = 0; b < 4; b++) begin
        e.data = w[31 - 8 * b -: 8];
        sum    = sum + 16'(e.data);
`ifdef DRAIN_CKSUM_EN
        e.last = 1'b0;
`else
        e.last = (i == n - 1) && (b == 3);
`endif
        sb.push_back(e);
      end
    end
`ifdef DRAIN_CKSUM_EN
    if (n > 0) begin
      e.data = sum[15:8]; e.last = 1'b0; sb.push_back(e);
      e.data = sum[7:0];  e.last = 1'b1; sb.push_back(e);
    end
`endif
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    return (mode == 0) ? 1'b1 : cyc[0];
  endfunction

  // Cycle 0 is the cycle in which dpram_run is high.
  task automatic run_frame(input int len, input int mode, output int done_cyc,
                           output int first_v, output int busy_cyc);
    int cyc;
    load_expect(len);
    @(posedge clk); #1;
    dpram_run = 1'b1;
    dpram_len = LW'(len);
    m_ready   = ready_for(mode, 0);
    cyc = 0; done_cyc = -1; first_v = -1; busy_cyc = 0;
    while (done_cyc < 0 && cyc < BUDGET) begin
      @(posedge clk); #1;
      dpram_run = 1'b0;
      cyc++;
      m_ready = ready_for(mode, cyc);
      @(negedge clk);
      if (dpram_busy) busy_cyc++;
      if (m_valid && first_v < 0) first_v = cyc;
      if (dpram_done) done_cyc = cyc;
    end
    check("done_within_budget", done_cyc >= 0, 1);
    check("busy_through_done", busy_cyc, done_cyc);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("idle_busy_low", dpram_busy, 0);
    check("done_one_cycle", dpram_done, 0);
    check("all_bytes_out", sb.size(), 0);
  endtask

  initial begin
    int done_cyc, first_v, busy_cyc, pulses_before;

    rst = 1'b0; dpram_run = 1'b0; dpram_len = '0; m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", dpram_busy, 0);
    check("rst_done", dpram_done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_data", m_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Two words, always ready.
    mem[0] = 32'h1122_3344; mem[1] = 32'hAABB_CCDD;
    run_frame(2, 0, done_cyc, first_v, busy_cyc);
    check("len2_first_valid", first_v, 3);
    check("len2_done_cycle", done_cyc, expected_done(2));

    // Empty frame.
    run_frame(0, 0, done_cyc, first_v, busy_cyc);
    check("len0_no_valid", first_v, -1);
    check("len0_done_cycle", done_cyc, 1);
    check("len0_busy_cycles", busy_cyc, 1);

    // One word with m_ready toggling every cycle.
    mem[0] = 32'h5A6B_7C8D;
    run_frame(1, 1, done_cyc, first_v, busy_cyc);
    check("len1_toggle_first_valid", first_v, 3);

    // Oversized length clamps to the DPRAM depth.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    run_frame(3000, 0, done_cyc, first_v, busy_cyc);
    check("clamp_done_cycle", done_cyc, expected_done(3000));
    check("clamp_final_addr", rd_addr, DEPTH - 1);

    // Reset while word index 4 of 10 is shifting out.
    for (int i = 0; i < 10; i++) mem[i] = 32'h0101_0101 * (i + 1);
    load_expect(10);
    pulses_before = done_pulses;
    @(posedge clk); #1;
    dpram_run = 1'b1; dpram_len = LW'(10);
    for (int c = 1; c <= 28; c++) begin
      @(posedge clk); #1;
      dpram_run = 1'b0;
      if (c == 28) rst = 1'b0;
      @(negedge clk);
      if (c == 27) begin
        check("abort_in_shift", m_valid, 1);
        check("abort_word_addr", rd_addr, 4);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_busy", dpram_busy, 0);
    check("abort_done", dpram_done, 0);
    check("abort_valid", m_valid, 0);
    check("abort_last", m_last, 0);
    check("abort_addr", rd_addr, 0);
    check("abort_data", m_data, 0);
    sb.delete();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_pulses, pulses_before);
    run_frame(2, 0, done_cyc, first_v, busy_cyc);
    check("after_abort_done_cycle", done_cyc, expected_done(2));
    check("after_abort_first_valid", first_v, 3);

    // Checksum-trailer vector (plain data frame when the trailer is disabled).
    mem[0] = 32'hFF01_02FF;
    run_frame(1, 0, done_cyc, first_v, busy_cyc);
    check("ck_done_cycle", done_cyc, expected_done(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
